commit_trace_serializer: RTL and testbench
==========================================

COMMIT_TRACE_SERIALIZER -- requirements
Module: commit_trace_serializer

Interface
REQ-001 Parameter DEPTH, default 16, is the FIFO entry count; legal values are powers of two and at least 8.
REQ-002 Parameter PC_BITS, default 40, is the commit PC width.
REQ-003 Parameter XLEN, default 64, is the writeback data width.
REQ-004 clock  input  1  sole clock; all state is updated on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; the block is in reset while reset=0.
REQ-006 commit_valid  input  4  per-lane architectural commit valid; bit i is lane i.
REQ-007 commit_pc  input  4*PC_BITS  per-lane PC; lane i occupies [i*PC_BITS +: PC_BITS].
REQ-008 commit_inst  input  4*32  per-lane instruction word.
REQ-009 commit_wdata  input  4*XLEN  per-lane scalar writeback data.
REQ-010 commit_ldst  input  4*5  per-lane logical destination register.
REQ-011 commit_rtype  input  4*3  per-lane destination register type.
REQ-012 out_valid  output  1  head entry is available.
REQ-013 out_ready  input  1  consumer accepts the head entry.
REQ-014 out_pc / out_inst / out_wdata / out_ldst / out_rtype  output  PC_BITS/32/XLEN/5/3  fields of the head entry.
REQ-015 out_lane  output  2  source lane of the head entry.
REQ-016 level  output  clog2(DEPTH)+1  current occupancy.
REQ-017 overflow  output  1  sticky flag; set when a commit group is dropped.
REQ-018 overflow_clr  input  1  synchronous clear for overflow (and for drop_cnt when that counter is present).

Function
REQ-019 Each cycle, npush = popcount(commit_valid) and free = DEPTH - level; free is the pre-pop value and is not increased by a pop in the same cycle.
REQ-020 When npush <= free, all valid lanes are written in ascending lane order into consecutive slots starting at wr_ptr, and invalid lanes leave no holes.
REQ-021 When npush > free, the whole group is dropped (no partial write) and overflow is set on the next edge.
REQ-022 A pop occurs when out_valid=1 and out_ready=1; rd_ptr then advances by one.
REQ-023 level_next = level + (accepted ? npush : 0) - pop; a push and a pop in the same cycle are both honoured.
REQ-024 wr_ptr and rd_ptr wrap modulo DEPTH.
REQ-025 out_valid = (level != 0).
REQ-026 While out_valid=1 and out_ready=0, all out_* fields are held stable.
REQ-027 When out_valid=0, all out_* data fields (out_pc, out_inst, out_wdata, out_ldst, out_rtype, out_lane) are driven to 0.
REQ-028 An entry written at edge N appears at the output after edge N when the FIFO was empty, giving one-cycle latency.
REQ-029 Entries leave the FIFO in strict commit order: older cycle first, then lower lane first within a cycle.
REQ-030 When overflow_clr and a new drop occur in the same cycle, set wins.
REQ-031 commit_* inputs are never backpressured, and npush=0 has no effect on state.

Reset
REQ-032 While reset=0: wr_ptr=0, rd_ptr=0, level=0, overflow=0, out_valid=0, out_* data fields=0, and drop_cnt=0 when present.
REQ-033 Assertion of reset mid-stream discards all entries immediately without waiting for a clock edge.
REQ-034 Storage array contents are not reset and are unobservable until rewritten.

Configuration
REQ-035 With macro COMMIT_TRACE_DROP_CNT_EN defined, output drop_cnt[15:0] exists and adds npush of each dropped group, saturating at 0xFFFF.
REQ-036 overflow_clr clears drop_cnt; when overflow_clr and a drop occur in the same cycle, drop_cnt loads that cycle's npush.
REQ-037 With COMMIT_TRACE_DROP_CNT_EN undefined, the drop_cnt port and its counter are absent, and all other behaviour is identical.

Verification
REQ-038 After reset release, commit_valid=4'b0100 with lane2 pc=0x80000000 -> next cycle out_valid=1, out_pc=0x80000000, out_lane=2, level=1.
REQ-039 commit_valid=4'b1011 with pcs 0x100/0x104/0x108/0x10C and out_ready=1 -> three consecutive outputs with out_pc 0x100, 0x104, 0x10C and out_lane 0, 1, 3; level ends at 0.
REQ-040 out_ready=0 and level=14, then commit_valid=4'b1111 -> level stays 14, overflow=1, drop_cnt=4 (macro on); overflow_clr pulse -> overflow=0, drop_cnt=0.
REQ-041 level=16, out_ready=1, commit_valid=4'b0001 -> group dropped, level=15, overflow=1.
REQ-042 Stream 40 entries with random commit_valid and random out_ready -> output PC sequence equals the input commit order across pointer wrap, with no loss while level stays below DEPTH.
REQ-043 level=9, reset driven to 0 between clock edges -> out_valid=0 and level=0 immediately; first commit after release appears at the output one cycle later.

Source files
------------

// File: rtl/commit_trace_serializer.sv
// Commit trace serializer: a 4-lane commit group goes into a FIFO in order and leaves one entry at a time.
// Optional drop counter output is enabled with macro COMMIT_TRACE_DROP_CNT_EN.
module commit_trace_serializer #(
  parameter int DEPTH   = 16,
  parameter int PC_BITS = 40,
  parameter int XLEN    = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [3:0]               i_commit_valid,
  input  logic [4*PC_BITS-1:0]     i_commit_pc,
  input  logic [4*32-1:0]          i_commit_inst,
  input  logic [4*XLEN-1:0]        i_commit_wdata,
  input  logic [4*5-1:0]           i_commit_ldst,
  input  logic [4*3-1:0]           i_commit_rtype,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [PC_BITS-1:0]       o_out_pc,
  output logic [31:0]              o_out_inst,
  output logic [XLEN-1:0]          o_out_wdata,
  output logic [4:0]               o_out_ldst,
  output logic [2:0]               o_out_rtype,
  output logic [1:0]               o_out_lane,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overflow,
  input  logic                     i_overflow_clr
`ifdef COMMIT_TRACE_DROP_CNT_EN
  ,output logic [15:0]             o_drop_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [PW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]        r_level;
  logic                 r_overflow;
  logic [2:0]           w_npush;
  logic [LW-1:0]        w_free;
  logic                 w_accept, w_drop, w_pop;
  logic [3:0][PW-1:0]   w_slot;

  logic [PC_BITS-1:0]   r_pc_mem    [DEPTH];
  logic [31:0]          r_inst_mem  [DEPTH];
  logic [XLEN-1:0]      r_wdata_mem [DEPTH];
  logic [4:0]           r_ldst_mem  [DEPTH];
  logic [2:0]           r_rtype_mem [DEPTH];
  logic [1:0]           r_lane_mem  [DEPTH];

  // Each valid lane lands at wr_ptr + (number of valid lanes below it), so no holes.
  always_comb begin
    w_npush = '0;
    for (int i = 0; i < 4; i++) begin
      w_slot[i] = r_wr_ptr + PW'(w_npush);
      w_npush   = w_npush + {2'b00, i_commit_valid[i]};
    end
  end

  assign w_free   = LW'(DEPTH) - r_level;
  assign w_accept = (w_npush != 3'd0) && (LW'(w_npush) <= w_free);
  assign w_drop   = (LW'(w_npush) > w_free);
  assign w_pop    = o_out_valid & i_out_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + PW'(w_npush);
      r_rd_ptr <= r_rd_ptr + PW'(w_pop);
      r_level  <= r_level + (w_accept ? LW'(w_npush) : '0) - LW'(w_pop);
      if (w_drop)              r_overflow <= 1'b1;
      else if (i_overflow_clr) r_overflow <= 1'b0;
    end
  end

  // Storage is deliberately unreset; the output mux hides stale contents.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      for (int i = 0; i < 4; i++) begin
        if (i_commit_valid[i]) begin
          r_pc_mem[w_slot[i]]    <= i_commit_pc[i*PC_BITS +: PC_BITS];
          r_inst_mem[w_slot[i]]  <= i_commit_inst[i*32 +: 32];
          r_wdata_mem[w_slot[i]] <= i_commit_wdata[i*XLEN +: XLEN];
          r_ldst_mem[w_slot[i]]  <= i_commit_ldst[i*5 +: 5];
          r_rtype_mem[w_slot[i]] <= i_commit_rtype[i*3 +: 3];
          r_lane_mem[w_slot[i]]  <= 2'(i);
        end
      end
    end
  end

  assign o_out_valid = (r_level != '0);
  assign o_out_pc    = o_out_valid ? r_pc_mem[r_rd_ptr]    : '0;
  assign o_out_inst  = o_out_valid ? r_inst_mem[r_rd_ptr]  : '0;
  assign o_out_wdata = o_out_valid ? r_wdata_mem[r_rd_ptr] : '0;
  assign o_out_ldst  = o_out_valid ? r_ldst_mem[r_rd_ptr]  : '0;
  assign o_out_rtype = o_out_valid ? r_rtype_mem[r_rd_ptr] : '0;
  assign o_out_lane  = o_out_valid ? r_lane_mem[r_rd_ptr]  : '0;
  assign o_level     = r_level;
  assign o_overflow  = r_overflow;

`ifdef COMMIT_TRACE_DROP_CNT_EN
  logic [15:0] r_drop_cnt;
  logic [16:0] w_dc_sum;

  assign w_dc_sum = {1'b0, r_drop_cnt} + 17'(w_npush);

  // A clear in the same cycle as a drop restarts the count from this drop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      if (i_overflow_clr)  r_drop_cnt <= 16'(w_npush);
      else if (w_dc_sum[16]) r_drop_cnt <= 16'hFFFF;
      else                 r_drop_cnt <= w_dc_sum[15:0];
    end else if (i_overflow_clr) begin
      r_drop_cnt <= '0;
    end
  end

  assign o_drop_cnt = r_drop_cnt;
`endif
endmodule

// File: tb/tb_commit_trace_serializer.sv
// Scoreboard bench for commit_trace_serializer: stimulus queues expected entries, a negedge monitor checks them.
module tb_commit_trace_serializer;
  localparam int DEPTH = 16;
  localparam int PCB   = 40;
  localparam int XL    = 64;

  typedef struct {
    logic [PCB-1:0] pc;
    logic [31:0]    inst;
    logic [XL-1:0]  wdata;
    logic [4:0]     ldst;
    logic [2:0]     rtype;
    logic [1:0]     lane;
  } ent_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [3:0]            c_valid;
  logic [4*PCB-1:0]      c_pc;
  logic [127:0]          c_inst;
  logic [4*XL-1:0]       c_wdata;
  logic [19:0]           c_ldst;
  logic [11:0]           c_rtype;
  logic                  out_ready;
  logic                  ovf_clr;
  logic                  o_valid;
  logic [PCB-1:0]        o_pc;
  logic [31:0]           o_inst;
  logic [XL-1:0]         o_wdata;
  logic [4:0]            o_ldst;
  logic [2:0]            o_rtype;
  logic [1:0]            o_lane;
  logic [4:0]            o_level;
  logic                  o_ovf;
`ifdef COMMIT_TRACE_DROP_CNT_EN
  logic [15:0]           o_dc;
`endif

  commit_trace_serializer #(.DEPTH(DEPTH), .PC_BITS(PCB), .XLEN(XL)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_commit_valid(c_valid), .i_commit_pc(c_pc),
    .i_commit_inst(c_inst), .i_commit_wdata(c_wdata), .i_commit_ldst(c_ldst),
    .i_commit_rtype(c_rtype), .o_out_valid(o_valid), .i_out_ready(out_ready),
    .o_out_pc(o_pc), .o_out_inst(o_inst), .o_out_wdata(o_wdata), .o_out_ldst(o_ldst),
    .o_out_rtype(o_rtype), .o_out_lane(o_lane), .o_level(o_level), .o_overflow(o_ovf),
    .i_overflow_clr(ovf_clr)
`ifdef COMMIT_TRACE_DROP_CNT_EN
    , .o_drop_cnt(o_dc)
`endif
  );

  always #5 clk = ~clk;

  ent_t q[$];
  int   lvl_now;
  bit   ovf_cur, ovf_nxt;
  int   dc_cur, dc_nxt;
  bit   mon_en = 1'b0;
  int   n_chk = 0, n_pass = 0;
  logic [PCB-1:0] pc_seq = 40'h1000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: outputs are stable here; a pop seen now happens at the next rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("level", 64'(o_level), 64'(lvl_now));
      chk("out_valid", 64'(o_valid), 64'(lvl_now != 0));
      chk("overflow", 64'(o_ovf), 64'(ovf_cur));
`ifdef COMMIT_TRACE_DROP_CNT_EN
      chk("drop_cnt", 64'(o_dc), 64'(dc_cur));
`endif
      if (lvl_now != 0) begin
        if (q.size() == 0) chk("scoreboard_empty", 64'(o_pc), 64'hDEAD);
        else begin
          chk("out_pc",    64'(o_pc),    64'(q[0].pc));
          chk("out_inst",  64'(o_inst),  64'(q[0].inst));
          chk("out_wdata", o_wdata,      q[0].wdata);
          chk("out_ldst",  64'(o_ldst),  64'(q[0].ldst));
          chk("out_rtype", 64'(o_rtype), 64'(q[0].rtype));
          chk("out_lane",  64'(o_lane),  64'(q[0].lane));
          if (out_ready) void'(q.pop_front());
        end
      end else begin
        chk("idle_zero", 64'({o_pc, o_inst, o_wdata, o_ldst, o_rtype, o_lane} != 0), 64'd0);
      end
    end
  end

  // One cycle of stimulus; the model decides acceptance from the pre-pop occupancy.
  task automatic cyc(input logic [3:0] v, input logic [4*PCB-1:0] pcs, input logic rdy, input logic clr);
    int   np;
    ent_t e;
    @(posedge clk); #1;
    ovf_cur = ovf_nxt;
    dc_cur  = dc_nxt;
    lvl_now = q.size();
    c_valid = v; c_pc = pcs; out_ready = rdy; ovf_clr = clr;
    for (int i = 0; i < 4; i++) begin
      c_inst[i*32 +: 32]  = $urandom;
      c_wdata[i*XL +: XL] = {$urandom, $urandom};
      c_ldst[i*5 +: 5]    = 5'($urandom);
      c_rtype[i*3 +: 3]   = 3'($urandom);
    end
    np = $countones(v);
    if (np <= DEPTH - lvl_now) begin
      for (int i = 0; i < 4; i++) if (v[i]) begin
        e.pc = pcs[i*PCB +: PCB]; e.inst = c_inst[i*32 +: 32]; e.wdata = c_wdata[i*XL +: XL];
        e.ldst = c_ldst[i*5 +: 5]; e.rtype = c_rtype[i*3 +: 3]; e.lane = 2'(i);
        q.push_back(e);
      end
      if (clr) begin ovf_nxt = 1'b0; dc_nxt = 0; end
    end else begin
      ovf_nxt = 1'b1;
      dc_nxt  = clr ? np : ((dc_cur + np > 65535) ? 65535 : dc_cur + np);
    end
  endtask

  task automatic seq_pcs(input logic [3:0] v, output logic [4*PCB-1:0] pcs);
    pcs = '0;
    for (int i = 0; i < 4; i++) if (v[i]) begin
      pcs[i*PCB +: PCB] = pc_seq;
      pc_seq = pc_seq + 4;
    end
  endtask

  task automatic fill(input logic [3:0] v);
    logic [4*PCB-1:0] p;
    seq_pcs(v, p);
    cyc(v, p, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) cyc(4'b0, '0, rdy, 1'b0);
  endtask

  // Asynchronous reset between edges; state must clear without a clock.
  task automatic mid_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(o_valid), 64'd0);
    chk("rst_level", 64'(o_level), 64'd0);
    chk("rst_overflow", 64'(o_ovf), 64'd0);
    q.delete();
    lvl_now = 0; ovf_cur = 0; ovf_nxt = 0; dc_cur = 0; dc_nxt = 0;
    c_valid = '0; ovf_clr = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0][PCB-1:0] pa;
    logic [4*PCB-1:0]    p;
    logic [3:0]          v;
    rst_n = 1'b0; c_valid = '0; c_pc = '0; c_inst = '0; c_wdata = '0; c_ldst = '0; c_rtype = '0;
    out_ready = 1'b0; ovf_clr = 1'b0;
    lvl_now = 0; ovf_cur = 0; ovf_nxt = 0; dc_cur = 0; dc_nxt = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 64'(o_valid), 64'd0);
    chk("reset_level", 64'(o_level), 64'd0);
    chk("reset_data", 64'({o_pc, o_lane} != 0), 64'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Single lane 2 commit appears one cycle later.
    pa = '0; pa[2] = 40'h8000_0000;
    cyc(4'b0100, pa, 1'b0, 1'b0);
    idle(1, 1'b0);
    idle(2, 1'b1);

    // Sparse group: lanes 0,1,3 drain as three consecutive outputs.
    pa = '0; pa[0] = 40'h100; pa[1] = 40'h104; pa[2] = 40'h108; pa[3] = 40'h10C;
    cyc(4'b1011, pa, 1'b1, 1'b0);
    idle(4, 1'b1);

    // Drop at level 14, then clear; then simultaneous drop+clear.
    fill(4'b1111); fill(4'b1111); fill(4'b1111); fill(4'b0011);
    fill(4'b1111);
    idle(1, 1'b0);
    cyc(4'b0, '0, 1'b0, 1'b1);
    idle(1, 1'b0);
    seq_pcs(4'b1111, p); cyc(4'b1111, p, 1'b0, 1'b1);
    idle(1, 1'b0);
    cyc(4'b0, '0, 1'b0, 1'b1);

    // Full FIFO with a pop: free is pre-pop, so the single-lane group is dropped.
    fill(4'b0011);
    seq_pcs(4'b0001, p); cyc(4'b0001, p, 1'b1, 1'b0);
    idle(2, 1'b0);
    cyc(4'b0, '0, 1'b1, 1'b1);
    idle(20, 1'b1);

    // Random stream across pointer wrap.
    for (int k = 0; k < 70; k++) begin
      v = 4'($urandom);
      seq_pcs(v, p);
      cyc(v, p, ($urandom_range(0, 9) < 7), ($urandom_range(0, 15) == 0));
    end
    idle(24, 1'b1);

    // Mid-stream reset at level 9, then first commit after release.
    fill(4'b1111); fill(4'b1111); fill(4'b0001);
    idle(1, 1'b0);
    mid_reset();
    pa = '0; pa[1] = 40'h2222;
    cyc(4'b0010, pa, 1'b0, 1'b0);
    idle(1, 1'b0);
    idle(3, 1'b1);

    @(posedge clk); #1;
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
